pipeline_hazard_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_if.sv | 32 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // Load in EX writes a register the ID instruction reads; r0 never hazards.
  function automatic logic load_use(
    input logic                 ex_mem_read,
    input logic [REG_IDX_W-1:0] ex_rt,
    input logic [REG_IDX_W-1:0] id_rs,
    input logic [REG_IDX_W-1:0] id_rt,
    input logic                 id_uses_rt
  );
    return ex_mem_read && (ex_rt != ZERO_REG) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs and stage-register controls between the ID stage and the controller.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [REG_IDX_W-1:0] id_rs;
  logic [REG_IDX_W-1:0] id_rt;
  logic                 id_uses_rt;
  logic                 ex_mem_read;
  logic [REG_IDX_W-1:0] ex_rt;
  logic                 branch_taken;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 pc_write;
  logic                 if_id_freeze;
  logic                 if_flush;
  logic                 id_ex_bubble;
  logic                 stall_all;
  logic                 err;
  logic [CNT_W-1:0]     stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_freeze, if_flush, id_ex_bubble, stall_all, err, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_freeze, if_flush, id_ex_bubble, stall_all, err, stall_count
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; async active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch flush,
// data-memory wait states with timeout, and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [1:0] S_RUN      = 2'(RUN);
  localparam logic [1:0] S_MEM_WAIT = 2'(MEM_WAIT);
  localparam logic [1:0] S_ERROR    = 2'(ERROR);

  logic [1:0]        r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_err;

  logic [1:0]        w_state_nxt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              w_err_nxt;
  logic              w_lu;
  logic              w_ms;
  logic              w_eval_id;
  logic              w_pc_write;
  logic              w_freeze;
  logic              w_flush;
  logic              w_bubble;
  logic              w_stall_all;
  logic [CNT_W-1:0]  w_stall_count;

  assign w_lu = load_use(bus.ex_mem_read, bus.ex_rt, bus.id_rs, bus.id_rt, bus.id_uses_rt);
  assign w_ms = bus.dmem_req && !bus.dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_wcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next state and zero-latency stage controls.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_err_nxt   = r_err;
    w_eval_id   = 1'b0;
    w_pc_write  = 1'b1;
    w_freeze    = 1'b0;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;
    w_stall_all = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_ms) begin
          w_pc_write  = 1'b0;
          w_freeze    = 1'b1;
          w_stall_all = 1'b1;
          w_state_nxt = S_MEM_WAIT;
          w_wcnt_nxt  = WCNT_W'(1);
        end else begin
          w_eval_id = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          w_state_nxt = S_RUN;
          w_wcnt_nxt  = '0;
          w_eval_id   = 1'b1;
        end else begin
          w_pc_write  = 1'b0;
          w_freeze    = 1'b1;
          w_stall_all = 1'b1;
          if (r_wcnt == WCNT_W'(MEM_TIMEOUT)) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 1'b1;
          end else begin
            w_wcnt_nxt = r_wcnt + WCNT_W'(1);
          end
        end
      end
      S_ERROR: begin
        w_pc_write  = 1'b0;
        w_freeze    = 1'b1;
        w_stall_all = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_wcnt_nxt  = '0;
      end
    endcase

    // Branch flush yields to a load-use stall: the branch re-resolves next cycle.
    if (w_eval_id) begin
      if (w_lu) begin
        w_pc_write = 1'b0;
        w_freeze   = 1'b1;
        w_bubble   = 1'b1;
      end else if (bus.branch_taken) begin
        w_flush = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (!w_pc_write),
    .o_count (w_stall_count)
  );

  // While reset is held the stage registers see a frozen, bubbled pipeline.
  assign bus.pc_write     = rst_n ? w_pc_write  : 1'b0;
  assign bus.if_id_freeze = rst_n ? w_freeze    : 1'b1;
  assign bus.if_flush     = rst_n ? w_flush     : 1'b0;
  assign bus.id_ex_bubble = rst_n ? w_bubble    : 1'b1;
  assign bus.stall_all    = rst_n ? w_stall_all : 1'b0;
  assign bus.err          = r_err;
  assign bus.stall_count  = w_stall_count;

endmodule
